// File: rtl/dbg_ctrl.sv
// dbg_ctrl: UART debug controller that halts/runs/steps the core and streams a reg or PC snapshot.
// Optional byte acknowledgements ('+' / '?') are enabled by defining DBG_ACK_EN.
module dbg_ctrl #(
  parameter bit          RESET_RUN   = 1'b1,
  parameter int unsigned ARG_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        core_en,
  output logic [4:0]  debug_sel,
  input  logic [31:0] debug_data,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        cmd_overrun
);
  typedef enum logic [2:0] {
    IDLE, ARG, LATCH, SEND, STEP
`ifdef DBG_ACK_EN
    , ACK
`endif
  } state_e;
  state_e      state_q, state_d;
  logic        core_q, core_d, src_q, src_d, ovr_q, ovr_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] snap_q, snap_d, cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
`ifdef DBG_ACK_EN
  logic [7:0]  ack_q, ack_d;
`endif
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    sel_d   = sel_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    ovr_d   = ovr_q | (rx_valid && state_q != IDLE && state_q != ARG);
`ifdef DBG_ACK_EN
    ack_d   = ack_q;
`endif
    case (state_q)
      IDLE: if (rx_valid) begin
        case (rx_data)
          8'h48, 8'h52: begin
            core_d = rx_data == 8'h52;
`ifdef DBG_ACK_EN
            state_d = ACK;
            ack_d   = 8'h2B;
`endif
          end
          8'h53: begin
            if (!core_q) state_d = STEP;
`ifdef DBG_ACK_EN
            else begin
              state_d = ACK;
              ack_d   = 8'h2B;
            end
`endif
          end
          8'h72: begin
            state_d = ARG;
            cnt_d   = '0;
          end
          8'h50: begin
            src_d   = 1'b1;
            state_d = LATCH;
          end
          default: begin
`ifdef DBG_ACK_EN
            state_d = ACK;
            ack_d   = 8'h3F;
`endif
          end
        endcase
      end
      ARG: begin
        cnt_d = cnt_q + 32'd1;
        if (rx_valid) begin
          sel_d   = rx_data[4:0];
          src_d   = 1'b0;
          state_d = LATCH;
        end else if (ARG_TIMEOUT != 0 && cnt_q == ARG_TIMEOUT - 1) state_d = IDLE;
      end
      LATCH: begin
        snap_d  = src_q ? pc : debug_data;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: if (tx_ready) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = IDLE;
      end
      STEP: begin
`ifdef DBG_ACK_EN
        state_d = ACK;
        ack_d   = 8'h2B;
`else
        state_d = IDLE;
`endif
      end
`ifdef DBG_ACK_EN
      ACK: if (tx_ready) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      core_q  <= RESET_RUN;
      sel_q   <= '0;
      snap_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DBG_ACK_EN
      ack_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      sel_q   <= sel_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ovr_q   <= ovr_d;
`ifdef DBG_ACK_EN
      ack_q   <= ack_d;
`endif
    end
  end
  // STEP overrides the halted enable for its single cycle
  assign core_en     = core_q | (state_q == STEP);
  assign debug_sel   = sel_q;
  assign busy        = state_q != IDLE;
  assign cmd_overrun = ovr_q;
`ifdef DBG_ACK_EN
  assign tx_valid = state_q == SEND || state_q == ACK;
  assign tx_data  = state_q == SEND ? snap_q[{idx_q, 3'b000} +: 8] : state_q == ACK ? ack_q : 8'h00;
`else
  assign tx_valid = state_q == SEND;
  assign tx_data  = state_q == SEND ? snap_q[{idx_q, 3'b000} +: 8] : 8'h00;
`endif
endmodule

// File: tb/tb_dbg_ctrl.sv
// tb_dbg_ctrl: table-driven directed bench for dbg_ctrl (default build, ARG_TIMEOUT=8).
module tb_dbg_ctrl;
  logic        clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] debug_data = '0, pc = '0;
  logic        tx_valid, core_en, busy, cmd_overrun;
  logic [7:0]  tx_data;
  logic [4:0]  debug_sel;
  int          checks = 0, errors = 0;

  dbg_ctrl #(.RESET_RUN(1'b1), .ARG_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .core_en(core_en), .debug_sel(debug_sel),
    .debug_data(debug_data), .pc(pc), .busy(busy), .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rv;
    logic [7:0]  rd;
    logic        tr;
    logic [31:0] pcv, dd;
    logic        tv;
    logic [7:0]  td;
    logic        ce;
    logic [4:0]  ds;
    logic        bz, ov;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic rst, input logic rv, input logic [7:0] rd, input logic tr,
                     input logic [31:0] pcv, input logic [31:0] dd, input logic tv,
                     input logic [7:0] td, input logic ce, input logic [4:0] ds,
                     input logic bz, input logic ov);
    vq.push_back('{rst, rv, rd, tr, pcv, dd, tv, td, ce, ds, bz, ov});
  endtask

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s got %h want %h", i, name, act, exp);
    end
  endtask

  initial begin
    int  n;
    bit  saw_tx;
    // rst rv rd  tr pc dd | tv td ce ds bz ov
    add(1, 0, 8'h00, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    add(0, 1, 8'h48, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h53, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h52, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    add(0, 1, 8'h53, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    add(0, 1, 8'h72, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0);
    add(0, 1, 8'h25, 1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 0, 32'hDEADBEEF, 1, 8'hEF, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'hBE, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'hAD, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'hDE, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 8'h00, 1, 5, 0, 0);
    add(0, 1, 8'h50, 0, 32'h40, 0, 0, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 0, 32'h40, 0, 1, 8'h40, 1, 5, 1, 0);
    add(0, 0, 8'h00, 0, 32'hFFFFFFFF, 0, 1, 8'h40, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 32'hFFFFFFFF, 0, 1, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 0, 32'hFFFFFFFF, 0, 1, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 32'hFFFFFFFF, 0, 1, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 0, 32'hFFFFFFFF, 0, 1, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 32'hFFFFFFFF, 0, 1, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 0, 32'hFFFFFFFF, 0, 1, 8'h00, 1, 5, 1, 0);
    add(0, 0, 8'h00, 1, 32'hFFFFFFFF, 0, 0, 8'h00, 1, 5, 0, 0);
    add(0, 1, 8'h50, 0, 32'h12345678, 0, 0, 8'h00, 1, 5, 1, 0);
    add(0, 1, 8'h48, 0, 32'h12345678, 0, 1, 8'h78, 1, 5, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'h56, 1, 5, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'h34, 1, 5, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'h12, 1, 5, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0,  0, 8'h00, 1, 5, 0, 1);
    add(0, 1, 8'h00, 0, 0, 0,  0, 8'h00, 1, 5, 0, 1);
    add(0, 1, 8'h72, 0, 0, 0,  0, 8'h00, 1, 5, 1, 1);
    add(0, 1, 8'hE3, 0, 0, 0,  0, 8'h00, 1, 3, 1, 1);
    add(0, 0, 8'h00, 1, 0, 32'h44332211, 1, 8'h11, 1, 3, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'h22, 1, 3, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0,  1, 8'h33, 1, 3, 1, 1);
    add(1, 0, 8'h00, 1, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; rx_valid = vq[i].rv; rx_data = vq[i].rd; tx_ready = vq[i].tr;
      pc = vq[i].pcv; debug_data = vq[i].dd;
      @(posedge clk); #1;
      chk("tx_valid", i, 32'(tx_valid), 32'(vq[i].tv));
      chk("tx_data", i, 32'(tx_data), 32'(vq[i].td));
      chk("core_en", i, 32'(core_en), 32'(vq[i].ce));
      chk("debug_sel", i, 32'(debug_sel), 32'(vq[i].ds));
      chk("busy", i, 32'(busy), 32'(vq[i].bz));
      chk("cmd_overrun", i, 32'(cmd_overrun), 32'(vq[i].ov));
    end
    // 'r' with no index byte: exactly eight ARG cycles, then IDLE with no reply
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h72; tx_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
    n = 0; saw_tx = 1'b0;
    while (busy && n < 20) begin
      saw_tx |= tx_valid;
      n++;
      @(posedge clk); #1;
    end
    chk("arg_timeout_cycles", 100, n, 8);
    chk("arg_timeout_no_tx", 100, 32'(saw_tx), 0);
    chk("arg_timeout_idle", 100, 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
